// File: rtl/seq_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_shifter                                                   |
// | Purpose  : Multi-cycle 16-bit shift engine. Captures an operand, an      |
// |            operation (LSL/LSR/ASR/ROR) and a 0-15 shift amount on an     |
// |            accepted start, then shifts one bit position per clock.       |
// |            It presents the result and the last bit shifted out with a    |
// |            one-cycle done pulse.                                         |
// | Ports    : clk    - clock, rising-edge active                            |
// |            rst_n  - asynchronous active-low reset                        |
// |            start  - request, honoured in IDLE and DONE only              |
// |            in     - 16-bit operand, captured with start                  |
// |            op     - 00 LSL, 01 LSR, 10 ASR, 11 ROR                       |
// |            amt    - shift count 0..15, captured with start               |
// |            busy   - high while shifting                                  |
// |            done   - one-cycle pulse, sout/carry valid                    |
// |            sout   - result register, held until the next accepted start  |
// |            carry  - last bit shifted/rotated out (0 when amt = 0)        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seq_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] in,
  input  logic [1:0]  op,
  input  logic [3:0]  amt,
  output logic        busy,
  output logic        done,
  output logic [15:0] sout,
  output logic        carry
);

  // State encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Operation encoding
  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [3:0] C_COUNT_ONE = 4'd1;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [1:0]  r_op;
  logic [3:0]  r_count;
  logic        w_accept;
  logic [15:0] w_step_sout;
  logic        w_step_carry;

  // A new request is taken only when the engine is not mid-shift.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ------------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          // A zero amount skips SHIFT entirely and reports on the next cycle.
          w_next_state = (amt != 4'd0) ? S_SHIFT : S_DONE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SHIFT: begin
        // Leave on the edge where the count falls from 1 to 0.
        if (r_count == C_COUNT_ONE) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_SHIFT;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Output decode: purely from state, no path from inputs
  // ------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Single-bit step of the selected operation
  // ------------------------------------------------------------------------
  always_comb begin
    w_step_sout  = sout;
    w_step_carry = carry;
    case (r_op)
      OP_LSL: begin
        w_step_sout  = {sout[14:0], 1'b0};
        w_step_carry = sout[15];
      end
      OP_LSR: begin
        w_step_sout  = {1'b0, sout[15:1]};
        w_step_carry = sout[0];
      end
      OP_ASR: begin
        w_step_sout  = {sout[15], sout[15:1]};
        w_step_carry = sout[0];
      end
      OP_ROR: begin
        w_step_sout  = {sout[0], sout[15:1]};
        w_step_carry = sout[0];
      end
      default: begin
        w_step_sout  = sout;
        w_step_carry = carry;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sout    <= 16'h0000;
      carry   <= 1'b0;
      r_op    <= OP_LSL;
      r_count <= 4'd0;
    end else if (w_accept) begin
      sout    <= in;
      carry   <= 1'b0;
      r_op    <= op;
      r_count <= amt;
    end else if (r_state == S_SHIFT) begin
      sout    <= w_step_sout;
      carry   <= w_step_carry;
      r_count <= r_count - 4'd1;
    end
  end

endmodule
`default_nettype wire
